// File: rtl/sysid_boot_checker_pkg.sv
// Shared constants for the system-ID boot checker: state encoding, slave word
// addresses and counter widths.
package sysid_boot_checker_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int LAT_W  = 2;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_ID  = 3'd1;
  localparam logic [2:0] S_LAT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS  = 3'd3;
  localparam logic [2:0] S_LAT_TS = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_RD_ID  = S_RD_ID,
    ST_LAT_ID = S_LAT_ID,
    ST_RD_TS  = S_RD_TS,
    ST_LAT_TS = S_LAT_TS,
    ST_DONE   = S_DONE
  } state_t;

endpackage

// File: rtl/sysid_boot_checker_read_timer.sv
// Wait/timeout counter and read-latency counter used by the boot checker FSM.
module sysid_read_timer
  import sysid_boot_checker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int READ_LATENCY   = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic wait_clr,
  input  logic wait_inc,
  input  logic lat_load,
  output logic wait_hit,
  output logic lat_done
);

  // wait_hit fires during the TIMEOUT_CYCLES-th consecutive stall cycle.
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);

  logic [CNT_W-1:0] wait_cnt;
  logic [LAT_W-1:0] lat_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (lat_load) begin
        lat_cnt <= LAT_LOAD;
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

  assign wait_hit = (wait_cnt == WAIT_LIMIT);
  assign lat_done = (lat_cnt == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the sysid ID and timestamp words over an Avalon-MM read master and
// reports whether they match the build-time expected values.
module sysid_boot_checker
  import sysid_boot_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1516721602,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              m_address,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value,
  output state_t            state_dbg
);

  // Handshake: m_read/m_address are held while m_waitrequest=1; a transfer is
  // accepted in the cycle where m_read=1 and m_waitrequest=0.

  state_t state, next_state;
  logic   start_q, auto_pend;
  logic   clr_results, cap_id, cap_ts, set_timeout;
  logic   lat_load, wait_clr, wait_inc, wait_hit, lat_done;

  sysid_read_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .READ_LATENCY   (READ_LATENCY)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .wait_clr (wait_clr),
    .wait_inc (wait_inc),
    .lat_load (lat_load),
    .wait_hit (wait_hit),
    .lat_done (lat_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      auto_pend <= (AUTO_START != 0);
      id_value  <= '0;
      ts_value  <= '0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= next_state;
      // A start seen while a sequence is running is dropped here.
      start_q   <= start && ((state == ST_IDLE) || (state == ST_DONE));
      auto_pend <= 1'b0;
      if (clr_results) begin
        id_value <= '0;
        ts_value <= '0;
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
      end
      if (cap_id) begin
        id_value <= m_readdata;
        id_ok    <= (m_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= m_readdata;
        ts_ok    <= (m_readdata == EXPECTED_TS);
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    clr_results = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    set_timeout = 1'b0;
    lat_load    = 1'b0;
    wait_clr    = 1'b1;
    wait_inc    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_q || auto_pend) begin
          clr_results = 1'b1;
          next_state  = ST_RD_ID;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        wait_clr = 1'b0;
        wait_inc = m_waitrequest;
        if (!m_waitrequest) begin
          wait_clr = 1'b1;
          if (READ_LATENCY == 0) begin
            if (state == ST_RD_ID) begin
              cap_id     = 1'b1;
              next_state = ST_RD_TS;
            end else begin
              cap_ts     = 1'b1;
              next_state = ST_DONE;
            end
          end else begin
            lat_load = 1'b1;
            if (state == ST_RD_ID) begin
              next_state = ST_LAT_ID;
            end else begin
              next_state = ST_LAT_TS;
            end
          end
        end else if (wait_hit) begin
          set_timeout = 1'b1;
          next_state  = ST_DONE;
        end
      end
      ST_LAT_ID: begin
        if (lat_done) begin
          cap_id     = 1'b1;
          next_state = ST_RD_TS;
        end
      end
      ST_LAT_TS: begin
        if (lat_done) begin
          cap_ts     = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_q) begin
          clr_results = 1'b1;
          next_state  = ST_RD_ID;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Bus outputs decode only the state register, so reset drops m_read at once.
  assign m_read    = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign m_address = (state == ST_RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: a zero-latency instance and a latency-2 instance,
// each with its own behavioural sysid slave, checked against an expected queue.
module tb_sysid_boot_checker;
  import sysid_boot_checker_pkg::*;

  localparam logic [31:0] GOOD_ID = 32'd0;
  localparam logic [31:0] GOOD_TS = 32'd1516721602;
  localparam logic [31:0] BAD_TS  = 32'h5A5A5A5A;
  localparam logic [31:0] JUNK    = 32'hDEADBEEF;
  localparam int          RW      = 67;
  localparam int          MAX_CYC = 60;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;

  logic a_m_address, a_m_read, a_busy, a_done, a_id_ok, a_ts_ok, a_timeout;
  logic b_m_address, b_m_read, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
  logic [31:0] a_id_value, a_ts_value, b_id_value, b_ts_value;
  state_t a_state, b_state;

  logic [1:0]  mr, ma, bz, dn, iok, tok, tmo, m_wait;
  logic [31:0] id_v [2];
  logic [31:0] ts_v [2];
  logic [31:0] rdata [2];
  state_t      st [2];

  logic [31:0] mem_id [2];
  logic [31:0] mem_ts [2];
  int          stall_n [2];
  logic        stuck [2];
  int          stall_cnt [2];
  int          pend_cnt [2];
  logic        pend_addr [2];

  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sysid_boot_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(10)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .m_address(a_m_address), .m_read(a_m_read), .m_readdata(rdata[0]),
    .m_waitrequest(m_wait[0]), .busy(a_busy), .done(a_done),
    .id_ok(a_id_ok), .ts_ok(a_ts_ok), .timeout(a_timeout),
    .id_value(a_id_value), .ts_value(a_ts_value), .state_dbg(a_state)
  );

  sysid_boot_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(10)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start),
    .m_address(b_m_address), .m_read(b_m_read), .m_readdata(rdata[1]),
    .m_waitrequest(m_wait[1]), .busy(b_busy), .done(b_done),
    .id_ok(b_id_ok), .ts_ok(b_ts_ok), .timeout(b_timeout),
    .id_value(b_id_value), .ts_value(b_ts_value), .state_dbg(b_state)
  );

  assign mr  = {b_m_read, a_m_read};
  assign ma  = {b_m_address, a_m_address};
  assign bz  = {b_busy, a_busy};
  assign dn  = {b_done, a_done};
  assign iok = {b_id_ok, a_id_ok};
  assign tok = {b_ts_ok, a_ts_ok};
  assign tmo = {b_timeout, a_timeout};
  assign id_v[0] = a_id_value;
  assign id_v[1] = b_id_value;
  assign ts_v[0] = a_ts_value;
  assign ts_v[1] = b_ts_value;
  assign st[0] = a_state;
  assign st[1] = b_state;

  // Slave model: stall_n wait cycles per read (or stuck forever), then data
  // valid in the acceptance cycle (instance a) or two cycles later (instance b).
  always_comb begin
    m_wait = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = stuck[i] | (mr[i] & (stall_cnt[i] < stall_n[i]));
    end
  end

  always_comb begin
    rdata[0] = JUNK;
    rdata[1] = JUNK;
    if (mr[0] && !m_wait[0]) rdata[0] = ma[0] ? mem_ts[0] : mem_id[0];
    if (pend_cnt[1] == 1) rdata[1] = pend_addr[1] ? mem_ts[1] : mem_id[1];
  end

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        stall_cnt[i] <= 0;
        pend_cnt[i]  <= 0;
        pend_addr[i] <= 1'b0;
      end else begin
        if (mr[i] && m_wait[i]) stall_cnt[i] <= stall_cnt[i] + 1;
        else stall_cnt[i] <= 0;
        if (mr[i] && !m_wait[i]) begin
          pend_addr[i] <= ma[i];
          pend_cnt[i]  <= (i == 1) ? 2 : 0;
        end else if (pend_cnt[i] > 0) begin
          pend_cnt[i] <= pend_cnt[i] - 1;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(posedge clock);
      #1;
      if (dn[0] && ca == 0) ca = c;
      if (dn[1] && cb == 0) cb = c;
      if (ca != 0 && cb != 0) break;
    end
  endtask

  task automatic push_exp(input logic t, input logic io, input logic to,
                          input logic [31:0] idw, input logic [31:0] tsw);
    exp_q.push_back({t, io, to, idw, tsw});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mr[i], ma[i], bz[i], dn[i], iok[i], tok[i], tmo[i]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got %b expected 0000000", i,
                 {mr[i], ma[i], bz[i], dn[i], iok[i], tok[i], tmo[i]});
      end
      checks++;
      if (id_v[i] !== 32'd0 || ts_v[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_words dut%0d: got %h/%h expected 0/0", i, id_v[i], ts_v[i]);
      end
      checks++;
      if (st[i] !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %0d expected %0d", i, st[i], ST_IDLE);
      end
    end
  endtask

  task automatic test_auto_start();
    int ca, cb;
    logic [RW-1:0] e;
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(ca, cb);
    checks++;
    if (ca != 3) begin
      errors++;
      $display("FAIL auto_done_cycle dut0: got %0d expected 3", ca);
    end
    checks++;
    if (cb != 15) begin
      errors++;
      $display("FAIL auto_done_cycle dut1: got %0d expected 15", cb);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tmo[i], iok[i], tok[i], id_v[i], ts_v[i]} !== e || bz[i] !== 1'b0) begin
        errors++;
        $display("FAIL auto_result dut%0d: got %h busy %b expected %h busy 0", i,
                 {tmo[i], iok[i], tok[i], id_v[i], ts_v[i]}, bz[i], e);
      end
    end
  endtask

  task automatic test_ts_mismatch();
    int ca, cb;
    logic [RW-1:0] e;
    mem_ts[0] = BAD_TS;
    mem_ts[1] = BAD_TS;
    push_exp(1'b0, 1'b1, 1'b0, GOOD_ID, BAD_TS);
    push_exp(1'b0, 1'b1, 1'b0, GOOD_ID, BAD_TS);
    pulse_start();
    wait_done(ca, cb);
    checks++;
    if (ca != 3 || cb != 15) begin
      errors++;
      $display("FAIL mismatch_done_cycle: got %0d/%0d expected 3/15", ca, cb);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tmo[i], iok[i], tok[i], id_v[i], ts_v[i]} !== e) begin
        errors++;
        $display("FAIL mismatch_result dut%0d: got %h expected %h", i,
                 {tmo[i], iok[i], tok[i], id_v[i], ts_v[i]}, e);
      end
    end
    mem_ts[0] = GOOD_TS;
    mem_ts[1] = GOOD_TS;
  endtask

  task automatic test_start_ignored();
    int cb;
    logic [RW-1:0] e;
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    pulse_start();
    @(posedge clock);
    #1;
    checks++;
    if (dn[0] !== 1'b0 || bz[0] !== 1'b1 || tok[0] !== 1'b0 || ts_v[0] !== 32'd0) begin
      errors++;
      $display("FAIL restart_clear dut0: got done %b busy %b ts_ok %b ts %h expected 0 1 0 0",
               dn[0], bz[0], tok[0], ts_v[0]);
    end
    @(posedge clock);
    #1;
    checks++;
    if (st[0] !== ST_RD_TS) begin
      errors++;
      $display("FAIL in_rd_ts dut0: got state %0d expected %0d", st[0], ST_RD_TS);
    end
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checks++;
    if (dn[0] !== 1'b1) begin
      errors++;
      $display("FAIL rerun_done dut0: got %b expected 1", dn[0]);
    end
    cb = 0;
    for (int c = 4; c <= MAX_CYC; c++) begin
      @(posedge clock);
      #1;
      if (dn[1]) begin
        cb = c;
        break;
      end
    end
    checks++;
    if (cb != 15) begin
      errors++;
      $display("FAIL rerun_done_cycle dut1: got %0d expected 15", cb);
    end
    repeat (4) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dn[i] !== 1'b1 || bz[i] !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_ignored dut%0d: got done %b busy %b expected 1 0", i, dn[i], bz[i]);
      end
      e = exp_q.pop_front();
      checks++;
      if ({tmo[i], iok[i], tok[i], id_v[i], ts_v[i]} !== e) begin
        errors++;
        $display("FAIL rerun_result dut%0d: got %h expected %h", i,
                 {tmo[i], iok[i], tok[i], id_v[i], ts_v[i]}, e);
      end
    end
  endtask

  task automatic test_timeout();
    int ca, cb;
    logic [RW-1:0] e;
    stuck[0] = 1'b1;
    push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    pulse_start();
    wait_done(ca, cb);
    checks++;
    if (ca != 11) begin
      errors++;
      $display("FAIL timeout_cycle dut0: got %0d expected 11", ca);
    end
    checks++;
    if (cb != 15) begin
      errors++;
      $display("FAIL timeout_peer_cycle dut1: got %0d expected 15", cb);
    end
    checks++;
    if (mr[0] !== 1'b0 || st[0] !== ST_DONE) begin
      errors++;
      $display("FAIL timeout_read_drop dut0: got m_read %b state %0d expected 0 %0d", mr[0], st[0], ST_DONE);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tmo[i], iok[i], tok[i], id_v[i], ts_v[i]} !== e) begin
        errors++;
        $display("FAIL timeout_result dut%0d: got %h expected %h", i,
                 {tmo[i], iok[i], tok[i], id_v[i], ts_v[i]}, e);
      end
    end
    @(negedge clock);
    stuck[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ca, cb;
    logic [RW-1:0] e;
    pulse_start();
    @(posedge clock);
    #1;
    checks++;
    if (mr[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_active dut0: got %b expected 1", mr[0]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mr[i], bz[i], dn[i]} !== 3'b000) begin
        errors++;
        $display("FAIL async_reset dut%0d: got read/busy/done %b expected 000", i, {mr[i], bz[i], dn[i]});
      end
    end
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    push_exp(1'b0, 1'b1, 1'b1, GOOD_ID, GOOD_TS);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(ca, cb);
    checks++;
    if (ca != 3 || cb != 15) begin
      errors++;
      $display("FAIL post_reset_cycle: got %0d/%0d expected 3/15", ca, cb);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tmo[i], iok[i], tok[i], id_v[i], ts_v[i]} !== e) begin
        errors++;
        $display("FAIL post_reset_result dut%0d: got %h expected %h", i,
                 {tmo[i], iok[i], tok[i], id_v[i], ts_v[i]}, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mem_id[i] = GOOD_ID;
      mem_ts[i] = GOOD_TS;
      stuck[i]  = 1'b0;
    end
    stall_n[0] = 0;
    stall_n[1] = 4;
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_start_ignored();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
